ecc_scrub_writeback: RTL
========================

Name: ecc_scrub_writeback

Overview:
- Sits directly downstream of the 512-bit Hamming SECDED checker on the L2 data read path.
- Captures every single-bit-corrected line and queues a scrub write of the corrected 523-bit coded line back to the data SRAM.
- Logs the line address of the first uncorrectable error, raises an interrupt, and keeps saturating error statistics.

Parameters:
- SCRUB_FIFO_DEPTH, 4: scrub queue entries; power of two, >= 2.
- ADDR_WIDTH, 26: cache line address width.
- COUNT_WIDTH, 16: width of the statistics counters.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- chk_valid  input  1  checker outputs are valid this cycle.
- chk_addr  input  ADDR_WIDTH  line address of the checked line.
- chk_error  input  1  checker detected at least one error.
- chk_corrected  input  1  checker corrected the error.
- chk_word_hamming  input  523  corrected coded line (hamming_512b_t).
- scrub_full  output  1  scrub queue full; registered.
- scrub_wb_valid  output  1  scrub write request.
- scrub_wb_addr  output  ADDR_WIDTH  scrub write address.
- scrub_wb_data  output  523  scrub write data.
- scrub_wb_ready  input  1  SRAM arbiter accepts the request.
- err_irq  output  1  uncorrectable-error interrupt.
- err_log_addr  output  ADDR_WIDTH  address of the first logged uncorrectable error.
- err_overflow  output  1  further uncorrectable errors arrived while logged.
- err_irq_clear  input  1  software acknowledge.
- scrub_dropped  output  1  sticky: a correctable event was lost because the queue was full.
- corrected_count  output  COUNT_WIDTH  corrected-event counter.
- uncorrectable_count  output  COUNT_WIDTH  uncorrectable-event counter.
- count_clear  input  1  zero both counters and scrub_dropped.

Behaviour:
- Reset values: all outputs 0; FIFO empty; pointers 0; FSM in IDLE.
- Event classes (sampled only when chk_valid=1):
  - correctable: chk_error=1, chk_corrected=1.
  - uncorrectable: chk_error=1, chk_corrected=0.
  - clean: chk_error=0. No action is taken.
- Scrub FIFO: SCRUB_FIFO_DEPTH entries of {addr, 523-bit data}.
  - Push occurs on a correctable event when the FIFO is not full.
  - Pop occurs when scrub_wb_valid && scrub_wb_ready.
  - Read and write pointers wrap modulo SCRUB_FIFO_DEPTH; an occupancy counter has width clog2(DEPTH)+1.
- Latency and output timing:
  - A push in cycle N makes scrub_wb_valid=1 no earlier than cycle N+1. There is no combinational bypass.
  - scrub_wb_valid = FIFO not empty.
  - scrub_wb_addr/data show the head entry and stay stable while valid && !ready.
- Full-queue handling:
  - A correctable event while full is dropped: FIFO unchanged, scrub_dropped set, corrected_count still increments.
  - A pop in the same cycle does not make room for the push.
  - Push and pop together when neither full nor empty: occupancy unchanged, data order preserved.
- scrub_full is registered and equals (occupancy == DEPTH). Upstream uses it to hold off reads.
- Error-log FSM, IDLE -> LOGGED:
  - IDLE + uncorrectable: latch chk_addr into err_log_addr; err_irq=1 from the next cycle.
  - LOGGED + uncorrectable: err_log_addr held; err_overflow set.
  - LOGGED + err_irq_clear: go to IDLE; err_irq=0 and err_overflow=0 next cycle. err_log_addr retains its value.
  - LOGGED + clear and uncorrectable in the same cycle: stay LOGGED, load the new address, err_overflow=0, err_irq stays 1.
  - err_irq_clear in IDLE has no effect.
- Counters:
  - Each counter increments by 1 per event of its class and saturates at all-ones.
  - count_clear has priority over the same-cycle increment and zeroes the counter; that event is not counted.
  - count_clear and a drop in the same cycle: scrub_dropped ends at 1.
- Reset asserted mid-operation: the FIFO is flushed and pending scrubs are lost. Outputs go to reset values asynchronously; release is synchronous to clk.

Test Plan:
- Reset, then one correctable event at addr 0x123 with data D -> scrub_wb_valid=1 next cycle with addr 0x123, data D; with scrub_wb_ready=1 valid drops the following cycle; corrected_count=1.
- Hold scrub_wb_ready=0 and send 5 correctable events (DEPTH=4) -> scrub_full=1 after the 4th; the 5th is dropped; scrub_dropped=1; corrected_count=5; drain yields the 4 addresses in order.
- Uncorrectable at 0x040, then uncorrectable at 0x080 -> err_irq=1, err_log_addr=0x040, err_overflow=1, uncorrectable_count=2.
- err_irq_clear in the same cycle as uncorrectable at 0x0C0 -> err_irq stays 1, err_log_addr=0x0C0, err_overflow=0.
- Saturation with COUNT_WIDTH=4: 17 correctable events -> corrected_count=15; count_clear together with an event -> counter=0.
- Assert reset with 3 entries queued -> scrub_wb_valid=0 immediately; FIFO empty after release.

Source files
------------

// File: rtl/ecc_scrub_writeback.sv
// ---------------------------------------------------------------------------
// ecc_scrub_writeback
//
// Sits behind the 512-bit Hamming SECDED checker on the L2 data read path.
// Every single-bit-corrected line is queued for a scrub write of the
// corrected 523-bit coded line back to the data SRAM. The first
// uncorrectable error is logged with its line address and raises an
// interrupt. Saturating statistics count both event classes.
//
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   chk_valid             checker outputs valid this cycle
//   chk_addr              line address of the checked line
//   chk_error             checker saw at least one error
//   chk_corrected         checker corrected the error
//   chk_word_hamming      corrected coded line (523 bits)
//   scrub_full            registered: scrub queue holds DEPTH entries
//   scrub_wb_valid/ready  scrub write request handshake to the SRAM arbiter
//   scrub_wb_addr/data    head-of-queue scrub write address and data
//   err_irq               uncorrectable-error interrupt
//   err_log_addr          address of the logged uncorrectable error
//   err_overflow          more uncorrectable errors arrived while logged
//   err_irq_clear         software acknowledge of err_irq
//   scrub_dropped         sticky: a correctable event was lost (queue full)
//   corrected_count       saturating corrected-event counter
//   uncorrectable_count   saturating uncorrectable-event counter
//   count_clear           zero both counters and scrub_dropped
//   err_state             debug view of the error-log FSM state (1 = LOGGED)
// ---------------------------------------------------------------------------
module ecc_scrub_writeback #(
    parameter int SCRUB_FIFO_DEPTH = 4,
    parameter int ADDR_WIDTH       = 26,
    parameter int COUNT_WIDTH      = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   chk_valid,
    input  logic [ADDR_WIDTH-1:0]  chk_addr,
    input  logic                   chk_error,
    input  logic                   chk_corrected,
    input  logic [522:0]           chk_word_hamming,
    output logic                   scrub_full,
    output logic                   scrub_wb_valid,
    output logic [ADDR_WIDTH-1:0]  scrub_wb_addr,
    output logic [522:0]           scrub_wb_data,
    input  logic                   scrub_wb_ready,
    output logic                   err_irq,
    output logic [ADDR_WIDTH-1:0]  err_log_addr,
    output logic                   err_overflow,
    input  logic                   err_irq_clear,
    output logic                   scrub_dropped,
    output logic [COUNT_WIDTH-1:0] corrected_count,
    output logic [COUNT_WIDTH-1:0] uncorrectable_count,
    input  logic                   count_clear,
    output logic                   err_state
);

    localparam int DATA_WIDTH = 523;
    localparam int PTR_W      = $clog2(SCRUB_FIFO_DEPTH);
    localparam int CNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(SCRUB_FIFO_DEPTH);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOGGED = 1'b1;

    // ---------------------------------------------------------------------
    // Event decode
    // ---------------------------------------------------------------------
    logic corr_event;
    logic unc_event;

    assign corr_event = chk_valid && chk_error && chk_corrected;
    assign unc_event  = chk_valid && chk_error && !chk_corrected;

    // ---------------------------------------------------------------------
    // Scrub FIFO
    //
    // Handshake: scrub_wb_valid is high whenever the queue is non-empty and
    // the head entry (scrub_wb_addr/data) is held stable until the cycle in
    // which scrub_wb_valid && scrub_wb_ready; that cycle pops the entry.
    // valid never depends combinationally on ready or on the checker inputs.
    // ---------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] fifo_addr [SCRUB_FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data [SCRUB_FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      occupancy;
    logic [CNT_W-1:0]      occ_next;
    logic                  push;
    logic                  pop;
    logic                  drop;

    // Push is gated by the registered full flag, so a same-cycle pop never
    // frees a slot for the incoming line.
    assign push = corr_event && !scrub_full;
    assign drop = corr_event && scrub_full;
    assign pop  = scrub_wb_valid && scrub_wb_ready;

    always_comb begin
        occ_next = occupancy;
        if (push && !pop) begin
            occ_next = occupancy + CNT_W'(1);
        end else if (pop && !push) begin
            occ_next = occupancy - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occupancy  <= '0;
            scrub_full <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            occupancy  <= occ_next;
            scrub_full <= (occ_next == DEPTH_CNT);
        end
    end

    // Storage is not reset; reset empties the queue through the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= chk_addr;
            fifo_data[wr_ptr] <= chk_word_hamming;
        end
    end

    // Head entry is masked while empty so the outputs read zero out of reset.
    assign scrub_wb_valid = (occupancy != '0);
    assign scrub_wb_addr  = scrub_wb_valid ? fifo_addr[rd_ptr] : '0;
    assign scrub_wb_data  = scrub_wb_valid ? fifo_data[rd_ptr] : '0;

    // ---------------------------------------------------------------------
    // Error-log FSM: IDLE -> LOGGED on an uncorrectable event
    // ---------------------------------------------------------------------
    logic [0:0] state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            err_log_addr <= '0;
            err_overflow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (unc_event) begin
                        state        <= ST_LOGGED;
                        err_log_addr <= chk_addr;
                        err_overflow <= 1'b0;
                    end
                end
                ST_LOGGED: begin
                    if (err_irq_clear && unc_event) begin
                        // Acknowledge and a fresh error together: re-arm on
                        // the new error rather than losing it.
                        err_log_addr <= chk_addr;
                        err_overflow <= 1'b0;
                    end else if (err_irq_clear) begin
                        state        <= ST_IDLE;
                        err_overflow <= 1'b0;
                    end else if (unc_event) begin
                        err_overflow <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign err_irq   = (state == ST_LOGGED);
    assign err_state = state;

    // ---------------------------------------------------------------------
    // Statistics
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            corrected_count     <= '0;
            uncorrectable_count <= '0;
            scrub_dropped       <= 1'b0;
        end else begin
            if (count_clear) begin
                corrected_count <= '0;
            end else if (corr_event && !(&corrected_count)) begin
                corrected_count <= corrected_count + COUNT_WIDTH'(1);
            end

            if (count_clear) begin
                uncorrectable_count <= '0;
            end else if (unc_event && !(&uncorrectable_count)) begin
                uncorrectable_count <= uncorrectable_count + COUNT_WIDTH'(1);
            end

            // A drop in the clearing cycle must stay visible.
            if (drop) begin
                scrub_dropped <= 1'b1;
            end else if (count_clear) begin
                scrub_dropped <= 1'b0;
            end
        end
    end

endmodule
